// File: rtl/csk_add_pipe_stage.sv
// csk_add_pipe_stage
//   Registered valid/ready stage around a 22-bit fixed-block carry-skip adder.
//   Operand pairs are buffered in a small FIFO; the FIFO head feeds the adder
//   combinationally and the 23-bit sum is captured in an output register.
//   A wrapping counter tracks completed output handshakes.
//
// Ports
//   CLK        rising-edge clock
//   RSTn       asynchronous active-low reset
//   IN_VALID   operand pair X/Y presented
//   IN_READY   FIFO can accept a pair this cycle (registered decode only)
//   X, Y       operands, W bits
//   OUT_VALID  S holds a valid sum
//   OUT_READY  consumer accepts S this cycle
//   S          registered sum X+Y, W+1 bits, carry-in 0
//   CNT        completed output handshakes, wraps at 2^CW
module csk_add_pipe_stage #(
    parameter int W     = 22,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  X,
    input  logic [W-1:0]  Y,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [W:0]    S,
    output logic [CW-1:0] CNT
);

    localparam int PW  = $clog2(DEPTH);
    localparam int BLK = 4;  // carry-skip block size; last block is partial
    localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

    generate
        if (W != 22 || (DEPTH != 2 && DEPTH != 4)) begin : g_bad_param
            $error("csk_add_pipe_stage: W must be 22, DEPTH must be 2 or 4");
        end
    endgenerate

    logic [DEPTH-1:0][2*W-1:0] mem;
    logic [PW-1:0]             wptr, rptr;
    logic [PW:0]               occ;
    logic                      push, load;
    logic [W-1:0]              hx, hy;
    logic [W:0]                sum;

    // Full/empty decode from the occupancy register only, so IN_READY never
    // depends combinationally on OUT_READY.
    assign IN_READY = (occ != OCC_FULL);
    assign push     = IN_VALID && IN_READY;
    assign load     = (occ != '0) && (!OUT_VALID || OUT_READY);

    assign hx = mem[rptr][2*W-1:W];
    assign hy = mem[rptr][W-1:0];

    // Carry-skip adder: ripple inside each block; when every bit of a block
    // propagates, the block carry-out is taken straight from its carry-in.
    logic rc, cin_blk, pall, p, g;
    always_comb begin
        sum     = '0;
        rc      = 1'b0;
        cin_blk = 1'b0;
        pall    = 1'b0;
        p       = 1'b0;
        g       = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i % BLK == 0) begin
                cin_blk = rc;
                pall    = 1'b1;
            end
            p      = hx[i] ^ hy[i];
            g      = hx[i] & hy[i];
            sum[i] = p ^ rc;
            rc     = g | (p & rc);
            pall   = pall & p;
            if ((i % BLK == BLK-1) || (i == W-1))
                rc = pall ? cin_blk : rc;
        end
        sum[W] = rc;
    end

    // Storage needs no reset: pointers and occupancy define what is live.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr] <= {X, Y};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            OUT_VALID <= 1'b0;
            S         <= '0;
            CNT       <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wptr <= wptr + 1'b1;
            if (load) rptr <= rptr + 1'b1;

            case ({push, load})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (load) begin
                S         <= sum;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;  // drained with nothing behind it; S holds
            end

            if (OUT_VALID && OUT_READY)
                CNT <= CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_csk_add_pipe_stage.sv
module tb_csk_add_pipe_stage;

    logic        CLK, RSTn, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [21:0] X, Y;
    logic [22:0] S;
    logic [15:0] CNT;

    int errors = 0;
    int checks = 0;

    logic [22:0] q[$];       // expected sums, in acceptance order
    logic [15:0] exp_cnt = '0;
    logic        prv_stall = 1'b0;
    logic [22:0] prv_s = '0;

    csk_add_pipe_stage #(.W(22), .DEPTH(2), .CW(16)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .X(X), .Y(Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .S(S), .CNT(CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, tracks the
    // handshake count and checks hold-during-stall.
    always @(negedge CLK) begin
        if (!RSTn) begin
            q.delete();
            exp_cnt   = '0;
            prv_stall = 1'b0;
        end else begin
            chk("cnt", 32'(CNT), 32'(exp_cnt));
            if (prv_stall) begin
                chk("stall_valid", 32'(OUT_VALID), 32'd1);
                chk("stall_s", 32'(S), 32'(prv_s));
            end
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(S), 32'hFFFF_FFFF);
                end else begin
                    chk("sum", 32'(S), 32'(q.pop_front()));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            prv_stall = OUT_VALID && !OUT_READY;
            prv_s     = S;
        end
    end

    // One cycle of stimulus; the expected sum is queued if the pair is accepted.
    task automatic step(input logic v, input logic [21:0] x, input logic [21:0] y, input logic r);
        IN_VALID  = v;
        X         = x;
        Y         = y;
        OUT_READY = r;
        @(negedge CLK);
        if (RSTn && IN_VALID && IN_READY)
            q.push_back({1'b0, X} + {1'b0, Y});
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn     = 1'b0;
        IN_VALID = 1'b1;      // pushes must be ignored in reset
        X        = 22'h123;
        Y        = 22'h456;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        RSTn     = 1'b1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || OUT_VALID) && n < 20) begin
            step(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk(name, 32'(q.size() != 0 || OUT_VALID), 32'd0);
    endtask

    initial begin
        int n;
        RSTn = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; X = '0; Y = '0;
        #1;
        chk("reset_s", 32'(S), 32'd0);
        chk("reset_cnt", 32'(CNT), 32'd0);
        do_reset();
        chk("post_rst_s", 32'(S), 32'd0);

        // Carry across all bits, no bypass of the empty FIFO
        step(1'b1, 22'h3FFFFF, 22'h000001, 1'b1);
        chk("no_bypass", 32'(OUT_VALID), 32'd0);
        step(1'b0, '0, '0, 1'b1);
        chk("lat_valid", 32'(OUT_VALID), 32'd1);
        chk("lat_sum", 32'(S), 32'h400000);
        step(1'b0, '0, '0, 1'b1);
        chk("cnt_one", 32'(CNT), 32'd1);

        // Back-to-back maximum and zero operands
        step(1'b1, 22'h3FFFFF, 22'h3FFFFF, 1'b1);
        step(1'b1, 22'h000000, 22'h000000, 1'b1);
        chk("b2b_first", 32'(S), 32'h7FFFFE);
        step(1'b0, '0, '0, 1'b1);
        chk("b2b_second", 32'(S), 32'h0);
        chk("b2b_second_v", 32'(OUT_VALID), 32'd1);
        step(1'b0, '0, '0, 1'b1);
        chk("b2b_idle", 32'(OUT_VALID), 32'd0);

        // Backpressure fills the FIFO; a pop while full admits no push
        do_reset();
        step(1'b1, 22'h1, 22'h2, 1'b0);
        step(1'b1, 22'h10, 22'h20, 1'b0);
        step(1'b1, 22'h100, 22'h200, 1'b0);
        chk("full_ready", 32'(IN_READY), 32'd0);
        chk("full_hold_s", 32'(S), 32'h3);
        step(1'b1, 22'h7, 22'h8, 1'b1);
        chk("pop_no_push_rdy", 32'(IN_READY), 32'd1);
        chk("pop_s", 32'(S), 32'h30);
        step(1'b0, '0, '0, 1'b1);
        chk("third_s", 32'(S), 32'h300);
        step(1'b0, '0, '0, 1'b1);
        chk("cnt_three", 32'(CNT), 32'd3);
        chk("empty_after", 32'(OUT_VALID), 32'd0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), 22'($urandom), 22'($urandom),
                 1'($urandom_range(0, 3) != 0));
        drain("rand_drain");

        // Stream until the counter reaches its top value, then wrap it
        n = 0;
        while (exp_cnt != 16'hFFFF && n < 70000) begin
            step(1'b1, 22'($urandom), 22'($urandom), 1'b1);
            n++;
        end
        chk("cnt_top", 32'(CNT), 32'hFFFF);
        chk("cnt_top_valid", 32'(OUT_VALID), 32'd1);
        step(1'b0, '0, '0, 1'b1);
        chk("cnt_wrap", 32'(CNT), 32'd0);
        drain("wrap_drain");

        // Asynchronous reset with a full FIFO and a pending result
        do_reset();
        step(1'b1, 22'h1, 22'h1, 1'b0);
        step(1'b1, 22'h2, 22'h2, 1'b0);
        step(1'b1, 22'h3, 22'h3, 1'b0);
        chk("pre_rst_valid", 32'(OUT_VALID), 32'd1);
        chk("pre_rst_full", 32'(IN_READY), 32'd0);
        IN_VALID = 1'b1;
        #2 RSTn = 1'b0;
        #1;
        chk("arst_valid", 32'(OUT_VALID), 32'd0);
        chk("arst_s", 32'(S), 32'd0);
        chk("arst_cnt", 32'(CNT), 32'd0);
        chk("arst_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        chk("arst_ready_hold", 32'(IN_READY), 32'd1);
        chk("arst_valid_hold", 32'(OUT_VALID), 32'd0);
        RSTn = 1'b1;
        step(1'b1, 22'h5, 22'h6, 1'b1);
        chk("post_arst_novld", 32'(OUT_VALID), 32'd0);
        step(1'b0, '0, '0, 1'b1);
        chk("post_arst_s", 32'(S), 32'hB);
        chk("post_arst_v", 32'(OUT_VALID), 32'd1);
        step(1'b0, '0, '0, 1'b1);
        chk("post_arst_cnt", 32'(CNT), 32'd1);
        drain("final_drain");
        chk("leftover", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
